// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding, default timing constants and counter type
// for the traffic phase sequencer.
package traffic_pkg;
    typedef enum logic [1:0] {
        PH_GREEN_A = 2'd0,
        PH_AMBER   = 2'd1,
        PH_GREEN_B = 2'd2
    } phase_e;

    localparam int TICK_DIV_D    = 4;
    localparam int AMBER_TICKS_D = 5;
    localparam int MIN_GREEN_A_D = 20;
    localparam int MAX_GREEN_B_D = 30;
    localparam int DEBOUNCE_D    = 3;
    localparam int CNT_W_D       = 8;

    typedef logic [CNT_W_D-1:0] cnt_t;
endpackage

// File: rtl/traffic_phase_sequencer_debounce.sv
// sensor_debounce: synchronizes a raw sensor and debounces it on timing ticks.
// Ports: clk, rstn (async active-low), tick (timing strobe), raw_in (asynchronous
// sensor), level_out (debounced car-present level).
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_D
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic raw_in,
    output logic level_out
);
    localparam int SW = $clog2(DEBOUNCE + 1);

    logic          s1;
    logic          s2;
    logic [SW-1:0] stab;

    // The level flips on the tick whose mismatch would bring stab to DEBOUNCE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            stab      <= '0;
            level_out <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
            if (tick) begin
                if (s2 != level_out) begin
                    if (stab == SW'(DEBOUNCE - 1)) begin
                        level_out <= ~level_out;
                        stab      <= '0;
                    end else begin
                        stab <= stab + 1'b1;
                    end
                end else begin
                    stab <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: tick prescaler, phase tracking, road-B request gating
// and amber timing beside the two-road light FSM.
// Ports: clk, rstn (async active-low), sensor_B (raw car sensor), amber_timer_en,
// green_light_A, green_light_B (from light FSM), traffic_B (gated request),
// timer_done (one-cycle amber expiry pulse), phase_cnt (debug tick count).
// Macro TRAFFIC_SEQ_STATS_EN adds serve_count and forced_count outputs.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_D,
    parameter int AMBER_TICKS = AMBER_TICKS_D,
    parameter int MIN_GREEN_A = MIN_GREEN_A_D,
    parameter int MAX_GREEN_B = MAX_GREEN_B_D,
    parameter int DEBOUNCE    = DEBOUNCE_D,
    parameter int CNT_W       = CNT_W_D
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sensor_B,
    input  logic             amber_timer_en,
    input  logic             green_light_A,
    input  logic             green_light_B,
    output logic             traffic_B,
    output logic             timer_done,
    output logic [CNT_W-1:0] phase_cnt
`ifdef TRAFFIC_SEQ_STATS_EN
    ,
    output logic [15:0]      serve_count,
    output logic [15:0]      forced_count
`endif
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;
    logic          tick;
    logic          car_present;
    logic          done_seen;
    logic          changed;
    logic          fire;
    logic          next_tb;
    logic          unused_green_a;
    phase_e        phase;
    phase_e        phase_in;

    // Road A green is the fallback phase, so its flag carries no extra information.
    assign unused_green_a = green_light_A;

    assign tick     = presc == PW'(TICK_DIV - 1);
    assign phase_in = amber_timer_en ? PH_AMBER : green_light_B ? PH_GREEN_B : PH_GREEN_A;
    assign changed  = phase_in != phase;
    assign fire     = phase == PH_AMBER && !changed && tick && !done_seen &&
                      phase_cnt == CNT_W'(AMBER_TICKS - 1);
    assign next_tb  = phase == PH_GREEN_A ? car_present && phase_cnt >= CNT_W'(MIN_GREEN_A) :
                      phase == PH_GREEN_B ? car_present && phase_cnt <  CNT_W'(MAX_GREEN_B) :
                      traffic_B;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk       (clk),
        .rstn      (rstn),
        .tick      (tick),
        .raw_in    (sensor_B),
        .level_out (car_present)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc      <= '0;
            phase      <= PH_GREEN_A;
            phase_cnt  <= '0;
            traffic_B  <= 1'b0;
            timer_done <= 1'b0;
            done_seen  <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            phase      <= phase_in;
            phase_cnt  <= changed ? '0 : (tick && phase_cnt != '1) ? phase_cnt + 1'b1 : phase_cnt;
            traffic_B  <= next_tb;
            timer_done <= fire;
            done_seen  <= phase_in == PH_AMBER && (done_seen || fire);
        end
    end

`ifdef TRAFFIC_SEQ_STATS_EN
    logic withdraw;

    // A withdrawal is the cycle where a live request is dropped by the road-B limit.
    assign withdraw = phase == PH_GREEN_B && traffic_B && car_present &&
                      phase_cnt >= CNT_W'(MAX_GREEN_B);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            serve_count  <= '0;
            forced_count <= '0;
        end else begin
            serve_count  <= (phase_in == PH_GREEN_B && changed && serve_count != 16'hFFFF) ?
                            serve_count + 16'd1 : serve_count;
            forced_count <= (withdraw && forced_count != 16'hFFFF) ?
                            forced_count + 16'd1 : forced_count;
        end
    end
`endif
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: randomized and directed checks against a behavioural model.
module tb_traffic_phase_sequencer;
    localparam int TD = 4;
    localparam int AT = 5;
    localparam int MG = 20;
    localparam int MB = 30;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sensor_B = 1'b0;
    logic       amber_timer_en = 1'b0;
    logic       green_light_A = 1'b0;
    logic       green_light_B = 1'b0;
    logic       traffic_B;
    logic       timer_done;
    logic [7:0] phase_cnt;
`ifdef TRAFFIC_SEQ_STATS_EN
    logic [15:0] serve_count;
    logic [15:0] forced_count;
`endif

    int checks = 0;
    int errors = 0;

    int         m_e;
    logic       h1, h2, m_car;
    int         m_stab;
    int         m_ph;
    int         m_cnt;
    logic       m_tb, m_done, m_seen;
    int         m_serve, m_forced;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .TICK_DIV(TD), .AMBER_TICKS(AT), .MIN_GREEN_A(MG),
        .MAX_GREEN_B(MB), .DEBOUNCE(DB), .CNT_W(8)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .sensor_B       (sensor_B),
        .amber_timer_en (amber_timer_en),
        .green_light_A  (green_light_A),
        .green_light_B  (green_light_B),
        .traffic_B      (traffic_B),
        .timer_done     (timer_done),
        .phase_cnt      (phase_cnt)
`ifdef TRAFFIC_SEQ_STATS_EN
        ,
        .serve_count    (serve_count),
        .forced_count   (forced_count)
`endif
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic model_reset();
        m_e = 0; h1 = 0; h2 = 0; m_car = 0; m_stab = 0; m_ph = 0; m_cnt = 0;
        m_tb = 0; m_done = 0; m_seen = 0; m_serve = 0; m_forced = 0;
    endtask

    // Phases: 0 = road A green, 1 = amber, 2 = road B green.
    // Ticks land on every TD-th clock edge counted from reset release.
    task automatic model_edge();
        logic tk, syn, ntb, nd;
        int nph;
        tk  = ((m_e + 1) % TD) == 0;
        syn = h2;
        nph = amber_timer_en ? 1 : green_light_B ? 2 : 0;
        ntb = (m_ph == 0) ? (m_car && m_cnt >= MG) : (m_ph == 2) ? (m_car && m_cnt < MB) : m_tb;
        nd  = (m_ph == 1) && (nph == 1) && tk && (m_cnt + 1 == AT) && !m_seen;
        if (m_ph == 2 && m_tb && m_car && m_cnt >= MB && m_forced < 65535) m_forced++;
        if (nph == 2 && m_ph != 2 && m_serve < 65535) m_serve++;
        if (nph != m_ph) m_cnt = 0;
        else if (tk && m_cnt < 255) m_cnt++;
        if (tk) begin
            if (syn != m_car) begin
                m_stab++;
                if (m_stab == DB) begin
                    m_car  = ~m_car;
                    m_stab = 0;
                end
            end else begin
                m_stab = 0;
            end
        end
        h2     = h1;
        h1     = sensor_B;
        m_seen = (nph == 1) && (m_seen || nd);
        m_tb   = ntb;
        m_done = nd;
        m_ph   = nph;
        m_e++;
    endtask

    task automatic step(input logic s, input logic a, input logic gb);
        sensor_B       = s;
        amber_timer_en = a;
        green_light_B  = gb;
        green_light_A  = !a && !gb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 0;
        sensor_B = 0; amber_timer_en = 0; green_light_A = 1; green_light_B = 0;
        model_reset();
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 0;
        #1;
        checks++;
        if ({traffic_B, timer_done, phase_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: tb/td/cnt got %b/%b/%0d want 0/0/0", traffic_B, timer_done, phase_cnt);
        end
`ifdef TRAFFIC_SEQ_STATS_EN
        checks++;
        if (serve_count !== 16'd0 || forced_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: serve/forced got %0d/%0d want 0/0", serve_count, forced_count);
        end
`endif
        model_reset();
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_min_green();
        int rise = -1;
        apply_reset();
        for (int i = 1; i <= 100; i++) begin
            step(1, 0, 0);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL min_green cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
            if (traffic_B === 1'b1 && rise < 0) rise = i;
        end
        checks++;
        if (rise != MG * TD + 1) begin
            errors++;
            $display("FAIL min_green_rise: rose at edge %0d want %0d", rise, MG * TD + 1);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int i = 1; i <= 100; i++) begin
            step(i <= 2 * TD, 0, 0);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL glitch cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
        end
        checks++;
        if (traffic_B !== 1'b0) begin
            errors++;
            $display("FAIL glitch_final: traffic_B got %b want 0", traffic_B);
        end
    endtask

    task automatic test_amber(input logic gb, input string name);
        int pulses = 0;
        int at = -1;
        apply_reset();
        for (int i = 1; i <= 60; i++) begin
            step(0, 1, gb);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL %s cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         name, i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
            if (timer_done === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        checks++;
        if (pulses != 1 || at != AT * TD) begin
            errors++;
            $display("FAIL %s_pulse: %0d pulses last at edge %0d want 1 at %0d", name, pulses, at, AT * TD);
        end
    endtask

    task automatic test_max_green_b();
        int fall = -1;
        apply_reset();
        for (int i = 1; i <= 140; i++) begin
            step(1, 0, 1);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL max_green_b cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
            if (i > 20 && traffic_B === 1'b0 && fall < 0) fall = i;
        end
        checks++;
        if (fall != MB * TD + 1) begin
            errors++;
            $display("FAIL max_green_b_fall: fell at edge %0d want %0d", fall, MB * TD + 1);
        end
`ifdef TRAFFIC_SEQ_STATS_EN
        checks++;
        if (serve_count !== 16'd1 || forced_count !== 16'd1) begin
            errors++;
            $display("FAIL max_green_b_stats: serve/forced got %0d/%0d want 1/1", serve_count, forced_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        apply_reset();
        for (int i = 1; i <= 70; i++) begin
            step(0, (i <= 30) || (i > 40), 0);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
            if (timer_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL back_to_back_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_early_drop();
        int pulses = 0;
        apply_reset();
        for (int i = 1; i <= 45; i++) begin
            step(0, i <= 15, 0);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL early_drop cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
            if (timer_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL early_drop_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        apply_reset();
        for (int i = 1; i <= 90; i++) step(1, 0, 0);
        while (phase_cnt !== 8'd3 && guard < 40) begin
            step(1, 1, 0);
            guard++;
        end
        checks++;
        if (guard >= 40 || traffic_B !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: cnt %0d tb %b after %0d amber cycles want cnt 3 tb 1",
                     phase_cnt, traffic_B, guard);
        end
        rstn = 0;
        #1;
        checks++;
        if ({traffic_B, timer_done, phase_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid: tb/td/cnt got %b/%b/%0d want 0/0/0", traffic_B, timer_done, phase_cnt);
        end
        model_reset();
        sensor_B = 0; amber_timer_en = 0; green_light_B = 0; green_light_A = 1;
        @(negedge clk);
        rstn = 1;
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0);
            checks++;
            if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                         i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic s = 0;
        apply_reset();
        for (int b = 0; b < 50; b++) begin
            int mode = $urandom_range(3);
            int len  = $urandom_range(1, 45);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(7) == 0) s = ~s;
                step(s, mode == 1 || mode == 3, mode >= 2);
                checks++;
                if ({traffic_B, timer_done, phase_cnt} !== {m_tb, m_done, 8'(m_cnt)}) begin
                    errors++;
                    $display("FAIL random blk %0d cyc %0d: tb/td/cnt got %b/%b/%0d want %b/%b/%0d",
                             b, i, traffic_B, timer_done, phase_cnt, m_tb, m_done, m_cnt);
                end
`ifdef TRAFFIC_SEQ_STATS_EN
                checks++;
                if (serve_count !== 16'(m_serve) || forced_count !== 16'(m_forced)) begin
                    errors++;
                    $display("FAIL random_stats blk %0d: serve/forced got %0d/%0d want %0d/%0d",
                             b, serve_count, forced_count, m_serve, m_forced);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_min_green();
        test_glitch();
        test_amber(1'b0, "amber");
        test_amber(1'b1, "priority");
        test_max_green_b();
        test_back_to_back();
        test_early_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
